// File: rtl/gen_gamma_pkg.sv
// Shared types and helpers for the generalized-gamma (Exp-Golomb order k) encoder/decoder pair.
package gen_gamma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    BODY   = 2'd2
  } state_t;

  // Longest codeword is 2*SIZE+1 bits; the length register must hold that value.
  function automatic int code_len_w(input int size);
    return $clog2(2 * size + 2);
  endfunction

  // Bit index into the SIZE+1-bit offset value v.
  function automatic int idx_w(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int unsigned sat_k(input int unsigned k, input int unsigned size);
    return (k > size - 1) ? size - 1 : k;
  endfunction

endpackage

// File: rtl/gen_gamma_msb_index.sv
// Combinational priority encoder: index of the highest set bit (0 when value is zero).
module gen_gamma_msb_index #(
  parameter int W  = 9,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  value,
  output logic [IW-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < W; i++) begin
      if (value[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/gen_gamma_encoder.sv
// Serial Exp-Golomb order-k encoder, MSB-first, one bit per transfer.
// Optional: define GEN_GAMMA_ENC_LEN_EN to add the code_len output.
module gen_gamma_encoder
  import gen_gamma_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int K_W  = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic [K_W-1:0]  in_k,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            bit_out,
  output logic            bit_last
`ifdef GEN_GAMMA_ENC_LEN_EN
  ,
  output logic [code_len_w(SIZE)-1:0] code_len
`endif
);

  localparam int VW = SIZE + 1;
  localparam int IW = idx_w(SIZE);
  localparam int CW = code_len_w(SIZE);

  // Handshakes: a word is taken on in_valid && in_ready, a bit is taken on
  // bit_valid && bit_ready; while bit_ready is low every output and counter holds.

  state_t          state, state_nxt;
  logic [VW-1:0]   v_q, v_in;
  logic [IW-1:0]   idx_q, zcnt_q;
  logic [IW-1:0]   msb, k_eff, zeros_in;
  logic [CW-1:0]   total_in;
  logic            accept, xfer;

  assign k_eff    = IW'(sat_k(32'(in_k), 32'(SIZE)));
  assign v_in     = {1'b0, in_data} + (VW'(1) << k_eff);

  gen_gamma_msb_index #(
    .W  (VW),
    .IW (IW)
  ) u_msb (
    .value (v_in),
    .index (msb)
  );

  // v >= 2^k_eff, so msb >= k_eff and the prefix length is never negative.
  assign zeros_in = msb - k_eff;
  assign total_in = (CW'(msb) << 1) + CW'(1) - CW'(k_eff);

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign bit_valid = (state != IDLE);
  assign xfer      = bit_valid && bit_ready;
  assign bit_out   = (state == BODY) && v_q[idx_q];
  assign bit_last  = (state == BODY) && (idx_q == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (zeros_in == '0) ? BODY : PREFIX;
      PREFIX:  if (xfer && zcnt_q == IW'(1)) state_nxt = BODY;
      BODY:    if (xfer && idx_q == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      v_q    <= '0;
      idx_q  <= '0;
      zcnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        v_q    <= v_in;
        idx_q  <= msb;
        zcnt_q <= zeros_in;
      end else if (xfer) begin
        if (state == PREFIX) zcnt_q <= zcnt_q - 1'b1;
        else if (idx_q != '0) idx_q <= idx_q - 1'b1;
      end
    end
  end

`ifdef GEN_GAMMA_ENC_LEN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         code_len <= '0;
    else if (accept) code_len <= total_in;
  end
`else
  logic unused_total;
  assign unused_total = ^total_in;
`endif

endmodule

// File: tb/tb_gen_gamma_encoder.sv
// Bench for gen_gamma_encoder: SIZE=8 instance plus a SIZE=6 instance for k saturation.
module tb_gen_gamma_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       bit_ready;
  logic       sel;
  logic [7:0] in_data;
  logic [2:0] in_k;

  logic a_in_ready, a_bit_valid, a_bit_out, a_bit_last;
  logic b_in_ready, b_bit_valid, b_bit_out, b_bit_last;
  logic m_in_ready, m_bit_valid, m_bit_out, m_bit_last;
  logic in_valid_a, in_valid_b;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  assign in_valid_a  = in_valid && !sel;
  assign in_valid_b  = in_valid && sel;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_bit_valid = sel ? b_bit_valid : a_bit_valid;
  assign m_bit_out   = sel ? b_bit_out   : a_bit_out;
  assign m_bit_last  = sel ? b_bit_last  : a_bit_last;

`ifdef GEN_GAMMA_ENC_LEN_EN
  logic [4:0] a_code_len;
  logic [3:0] b_code_len;
  logic [4:0] m_code_len;
  assign m_code_len = sel ? 5'(b_code_len) : a_code_len;
`endif

  gen_gamma_encoder #(.SIZE(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .bit_valid (a_bit_valid),
    .bit_ready (bit_ready),
    .bit_out   (a_bit_out),
    .bit_last  (a_bit_last)
`ifdef GEN_GAMMA_ENC_LEN_EN
    ,
    .code_len  (a_code_len)
`endif
  );

  gen_gamma_encoder #(.SIZE(6)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (b_in_ready),
    .in_data   (in_data[5:0]),
    .in_k      (in_k),
    .bit_valid (b_bit_valid),
    .bit_ready (bit_ready),
    .bit_out   (b_bit_out),
    .bit_last  (b_bit_last)
`ifdef GEN_GAMMA_ENC_LEN_EN
    ,
    .code_len  (b_code_len)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference codeword: (N-1-k) zeros followed by v = data + 2^k, MSB first.
  function automatic void build_exp(input int size, input int data, input int k);
    int ke, v, n;
    ke = (k > size - 1) ? size - 1 : k;
    v  = data + (1 << ke);
    n  = $clog2(v + 1);
    exp_q.delete();
    repeat (n - 1 - ke) exp_q.push_back(1'b0);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(1'((v >> i) & 1));
  endfunction

  // mode 0: bit_ready high; 1: random bit_ready plus ignored requests while busy;
  // 2: three stall cycles on the second bit. abort_at >= 0 pulses rst after that many bits.
  task automatic run_code(input int data, input int k, input int mode, input int abort_at);
    int n, got, cyc, stalls;
    build_exp(sel ? 6 : 8, data, k);
    n = exp_q.size();
    cyc = 0;
    while (!m_in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_before", int'(m_in_ready), 1);
    in_valid  = 1'b1;
    in_data   = 8'(data);
    in_k      = 3'(k);
    bit_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = (mode == 1);
    in_data  = 8'($urandom);
    in_k     = 3'($urandom);
    got = 0; cyc = 0; stalls = 0;
    while (got < n && cyc < 200) begin
      if (mode == 1)      bit_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) bit_ready = !(got == 1 && stalls < 3);
      else                bit_ready = 1'b1;
      @(negedge clk);
      check("bit_valid", int'(m_bit_valid), 1);
      check("busy_ready", int'(m_in_ready), 0);
      check("bit_out", int'(m_bit_out), int'(exp_q[got]));
      check("bit_last", int'(m_bit_last), int'(got == n - 1));
      if (bit_ready) got++;
      else stalls++;
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && got == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_valid", int'(m_bit_valid), 0);
        check("abort_out", int'(m_bit_out), 0);
        check("abort_last", int'(m_bit_last), 0);
        check("abort_ready", int'(m_in_ready), 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    in_valid  = 1'b0;
    bit_ready = 1'b1;
    check("bits_done", got, n);
    if (mode == 2) check("stall_cycles", stalls, 3);
`ifdef GEN_GAMMA_ENC_LEN_EN
    check("code_len", int'(m_code_len), n);
`endif
    @(negedge clk);
    check("idle_valid", int'(m_bit_valid), 0);
    check("idle_ready", int'(m_in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; bit_ready = 1'b1; sel = 1'b0;
    in_data = '0; in_k = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(a_bit_valid), 0);
    check("rst_out", int'(a_bit_out), 0);
    check("rst_last", int'(a_bit_last), 0);
    check("rst_ready", int'(a_in_ready), 1);
`ifdef GEN_GAMMA_ENC_LEN_EN
    check("rst_code_len", int'(a_code_len), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_code(0, 0, 0, -1);
    run_code(3, 0, 0, -1);
    run_code(5, 2, 0, -1);
    run_code(255, 0, 0, -1);
    run_code(0, 7, 0, -1);
    run_code(255, 7, 0, -1);
    run_code(3, 0, 2, -1);
    run_code(255, 0, 0, 12);
    run_code(77, 1, 0, -1);
    for (int i = 0; i < 30; i++)
      run_code(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1, -1);

    sel = 1'b1;
    run_code(0, 7, 0, -1);
    run_code(63, 7, 0, -1);
    run_code(5, 6, 0, -1);
    for (int i = 0; i < 12; i++)
      run_code(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
